// File: rtl/spi_cmd_master.sv
// rtl/spi_cmd_master.sv - SPI mode-0 master issuing command frames with full-duplex capture
module spi_cmd_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       CLKCPU_A,
    input  logic       RESET_n,
    input  logic       START,
    input  logic [7:0] CMD,
    input  logic [3:0] LEN,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_REQ,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       BUSY,
    output logic       DONE,
    output logic       SPI_SCK,
    output logic       SPI_NSS,
    output logic       SPI_MOSI,
    input  logic       SPI_MISO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_HOLD
    } state_t;

    // Last value of the half-period counter before a phase ends.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    // Counter value in GAP on which TX_REQ is raised, so that the first
    // possible handshake lands exactly on the last cycle of the minimum gap.
    localparam logic [7:0] REQ_AT   = (CLK_DIV >= 2) ? 8'(CLK_DIV - 2) : 8'd0;
    // With a one-cycle half period the gap is ready from its first cycle.
    localparam logic       REQ_ON_ENTRY = (CLK_DIV == 1) ? 1'b1 : 1'b0;

    state_t     state;
    logic [7:0] cnt;        // cycles spent in the current half period / phase
    logic [2:0] bit_cnt;    // bit index within the current byte, 0 = MSB
    logic [3:0] remaining;  // data bytes still to be accepted in this frame
    logic [6:0] tx_sr;      // bits still to be sent after the one on MOSI
    logic [7:0] rx_sr;      // MISO bits gathered so far, MSB first

    // Frame sequencer: all SPI pins and host strobes are registered here.
    always_ff @(posedge CLKCPU_A or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            bit_cnt   <= 3'd0;
            remaining <= 4'd0;
            tx_sr     <= 7'd0;
            rx_sr     <= 8'd0;
            TX_REQ    <= 1'b0;
            RX_DATA   <= 8'h00;
            RX_VALID  <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            SPI_SCK   <= 1'b0;
            SPI_NSS   <= 1'b1;
            SPI_MOSI  <= 1'b0;
        end else begin
            RX_VALID <= 1'b0;
            DONE     <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A START landing on the DONE cycle is dropped, which
                    // guarantees at least one cycle of NSS high between frames.
                    if (START && !DONE) begin
                        tx_sr     <= CMD[6:0];
                        SPI_MOSI  <= CMD[7];
                        remaining <= LEN;
                        SPI_NSS   <= 1'b0;
                        BUSY      <= 1'b1;
                        cnt       <= 8'd0;
                        state     <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (cnt == DIV_LAST) begin
                        cnt     <= 8'd0;
                        bit_cnt <= 3'd0;
                        state   <= S_SHIFT;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                S_SHIFT: begin
                    if (cnt != DIV_LAST) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        cnt <= 8'd0;
                        if (!SPI_SCK) begin
                            // Rising edge: capture MISO as SCK goes high.
                            SPI_SCK <= 1'b1;
                            rx_sr   <= {rx_sr[6:0], SPI_MISO};
                        end else begin
                            // Falling edge: advance MOSI or close the byte.
                            SPI_SCK <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                RX_DATA  <= rx_sr;
                                RX_VALID <= 1'b1;
                                if (remaining != 4'd0) begin
                                    TX_REQ <= REQ_ON_ENTRY;
                                    state  <= S_GAP;
                                end else begin
                                    state <= S_HOLD;
                                end
                            end else begin
                                bit_cnt  <= bit_cnt + 3'd1;
                                SPI_MOSI <= tx_sr[6];
                                tx_sr    <= {tx_sr[5:0], 1'b0};
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (TX_REQ && TX_VALID) begin
                        TX_REQ    <= 1'b0;
                        tx_sr     <= TX_DATA[6:0];
                        SPI_MOSI  <= TX_DATA[7];
                        remaining <= remaining - 4'd1;
                        bit_cnt   <= 3'd0;
                        cnt       <= 8'd0;
                        state     <= S_SHIFT;
                    end else begin
                        if (cnt == REQ_AT) begin
                            TX_REQ <= 1'b1;
                        end
                        // Saturate so a stalled gap keeps waiting without wrapping.
                        if (cnt != DIV_LAST) begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end

                S_HOLD: begin
                    if (cnt == DIV_LAST) begin
                        cnt      <= 8'd0;
                        SPI_NSS  <= 1'b1;
                        SPI_MOSI <= 1'b0;
                        BUSY     <= 1'b0;
                        DONE     <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
